gen_equations_sequencer: RTL and testbench

//  Parametrised successor to the fixed 16-state equation-generation controller.

---
 rtl/gen_eq_pkg.sv | 39 +++
 rtl/gen_eq_watchdog.sv | 37 +++
 rtl/gen_equations_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_gen_equations_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_eq_pkg.sv
// Shared definitions for the equation-generation sequencer: state encodings,
// error codes and element-type bit positions.
package gen_eq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_CHOOSE  = 4'd2,
    ST_STATUS  = 4'd3,
    ST_TYPE    = 4'd4,
    ST_VOLT    = 4'd5,
    ST_CURR    = 4'd6,
    ST_SELF    = 4'd7,
    ST_OTHER   = 4'd8,
    ST_COMPUTE = 4'd9,
    ST_RES     = 4'd10,
    ST_NEXT    = 4'd11,
    ST_DONE    = 4'd12,
    ST_ERROR   = 4'd13
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_TYPE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

  // Bit positions inside the one-hot elem_type input.
  localparam int unsigned ELEM_VOLT = 0;
  localparam int unsigned ELEM_CURR = 1;
  localparam int unsigned ELEM_RES  = 2;

  function automatic logic is_busy(input state_e s);
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/gen_eq_watchdog.sv
// Per-state stall watchdog: counts cycles spent in one busy state and flags
// expiry on the cycle the TIMEOUT_CYC-th edge would be taken without a move.
module gen_eq_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic busy,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = busy && (cnt_q == W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart || !busy) begin
      cnt_d = '0;
    end else if (!expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gen_equations_sequencer.sv
// Equation-generation controller: node loop, element dispatch, multi-phase
// resistor compute, fault codes and statistics. GEN_EQ_WATCHDOG_EN adds a stall watchdog.
module gen_equations_sequencer
  import gen_eq_pkg::*;
#(
  parameter int unsigned NUM_COMPUTE = 4,
  parameter int unsigned CW          = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic             clk,
  input  logic             program_reset_n,
  input  logic             start_process,
  input  logic             abort,
  input  logic             data_reset_done,
  input  logic             matrix_initialized,
  input  logic             node_chosen,
  input  logic             loop_done,
  input  logic             status_checked,
  input  logic             node_valid,
  input  logic             type_checked,
  input  logic [2:0]       elem_type,
  input  logic             stamp_done,
  input  logic             self_data_got,
  input  logic             other_data_got,
  input  logic             compute_done,
  input  logic             next_element_got,
  input  logic             end_of_list,
  output logic             go_reset_data,
  output logic             go_initialize_matrix,
  output logic             go_choose_node,
  output logic             go_check_node_status,
  output logic             go_check_element_type,
  output logic             go_voltage,
  output logic             go_current,
  output logic             go_get_self_data,
  output logic             go_get_other_data,
  output logic             go_compute,
  output logic             go_resistor,
  output logic             go_get_next_element,
  output logic [CW-1:0]    compute_idx,
  output logic             end_process,
  output logic             error,
  output logic [1:0]       error_code,
  output logic             busy,
  output logic [CNT_W-1:0] elem_count,
  output logic [CNT_W-1:0] node_count,
  output logic [3:0]       state
);

  localparam logic [2:0]    TYPE_VOLT  = 3'(1 << ELEM_VOLT);
  localparam logic [2:0]    TYPE_CURR  = 3'(1 << ELEM_CURR);
  localparam logic [2:0]    TYPE_RES   = 3'(1 << ELEM_RES);
  localparam logic [CW-1:0] LAST_PHASE = CW'(NUM_COMPUTE - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] elem_q, elem_d;
  logic [CNT_W-1:0] node_q, node_d;
  logic [1:0]       err_q, err_d;
  logic             inc_elem, inc_node, clr_stats;
  logic             state_chg;
  logic             wd_expired;

  always_ff @(posedge clk or negedge program_reset_n) begin
    if (!program_reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      elem_q  <= '0;
      node_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      elem_q  <= elem_d;
      node_q  <= node_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    inc_elem  = 1'b0;
    inc_node  = 1'b0;
    clr_stats = 1'b0;
    case (state_q)
      ST_IDLE: if (data_reset_done && start_process) begin
        state_d   = ST_INIT;
        clr_stats = 1'b1;
        err_d     = ERR_NONE;
      end
      ST_INIT: if (matrix_initialized) state_d = ST_CHOOSE;
      ST_CHOOSE: begin
        if (node_chosen)    state_d = ST_STATUS;
        else if (loop_done) state_d = ST_DONE;
      end
      ST_STATUS: if (status_checked) begin
        if (node_valid) begin
          state_d  = ST_TYPE;
          inc_node = 1'b1;
        end else begin
          state_d  = ST_CHOOSE;
        end
      end
      ST_TYPE: if (type_checked) begin
        if (elem_type == TYPE_RES) begin
          state_d = ST_SELF;
          idx_d   = '0;
        end else if (elem_type == TYPE_CURR) begin
          state_d = ST_CURR;
        end else if (elem_type == TYPE_VOLT) begin
          state_d = ST_VOLT;
        end else begin
          state_d = ST_ERROR;
          err_d   = ERR_BAD_TYPE;
        end
      end
      ST_VOLT, ST_CURR, ST_RES: if (stamp_done) begin
        state_d  = ST_NEXT;
        inc_elem = 1'b1;
      end
      ST_SELF:  if (self_data_got)  state_d = ST_OTHER;
      ST_OTHER: if (other_data_got) state_d = ST_COMPUTE;
      ST_COMPUTE: if (compute_done) begin
        if (idx_q == LAST_PHASE) begin
          state_d = ST_RES;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + CW'(1);
        end
      end
      ST_NEXT: begin
        if (end_of_list)           state_d = ST_CHOOSE;
        else if (next_element_got) state_d = ST_TYPE;
      end
      ST_DONE:  if (!start_process) state_d = ST_IDLE;
      ST_ERROR: if (!start_process) state_d = ST_IDLE;
      default: begin
        state_d = ST_ERROR;
        err_d   = ERR_ILLEGAL;
      end
    endcase

    // Timeout only fires when the normal rules would leave the state unchanged.
    if (wd_expired && (state_d == state_q)) begin
      state_d = ST_ERROR;
      err_d   = ERR_TIMEOUT;
    end

    if (abort) begin
      state_d   = ST_IDLE;
      idx_d     = idx_q;
      err_d     = err_q;
      inc_elem  = 1'b0;
      inc_node  = 1'b0;
      clr_stats = 1'b0;
    end
  end

  always_comb begin
    elem_d = elem_q;
    node_d = node_q;
    if (clr_stats) begin
      elem_d = '0;
      node_d = '0;
    end else begin
      if (inc_elem && (elem_q != '1)) elem_d = elem_q + CNT_W'(1);
      if (inc_node && (node_q != '1)) node_d = node_q + CNT_W'(1);
    end
  end

  always_comb begin
    go_reset_data         = 1'b0;
    go_initialize_matrix  = 1'b0;
    go_choose_node        = 1'b0;
    go_check_node_status  = 1'b0;
    go_check_element_type = 1'b0;
    go_voltage            = 1'b0;
    go_current            = 1'b0;
    go_get_self_data      = 1'b0;
    go_get_other_data     = 1'b0;
    go_compute            = 1'b0;
    go_resistor           = 1'b0;
    go_get_next_element   = 1'b0;
    case (state_q)
      ST_IDLE:    go_reset_data         = 1'b1;
      ST_INIT:    go_initialize_matrix  = 1'b1;
      ST_CHOOSE:  go_choose_node        = 1'b1;
      ST_STATUS:  go_check_node_status  = 1'b1;
      ST_TYPE:    go_check_element_type = 1'b1;
      ST_VOLT:    go_voltage            = 1'b1;
      ST_CURR:    go_current            = 1'b1;
      ST_SELF:    go_get_self_data      = 1'b1;
      ST_OTHER:   go_get_other_data     = 1'b1;
      ST_COMPUTE: go_compute            = 1'b1;
      ST_RES:     go_resistor           = 1'b1;
      ST_NEXT:    go_get_next_element   = 1'b1;
      default:    ;
    endcase
  end

  assign end_process = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERROR);
  assign busy        = is_busy(state_q);
  assign error_code  = err_q;
  assign compute_idx = idx_q;
  assign elem_count  = elem_q;
  assign node_count  = node_q;
  assign state       = state_q;
  assign state_chg   = (state_d != state_q);

`ifdef GEN_EQ_WATCHDOG_EN
  gen_eq_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (program_reset_n),
    .restart (state_chg),
    .busy    (busy),
    .expired (wd_expired)
  );
`else
  logic unused_wd;
  assign wd_expired = 1'b0;
  assign unused_wd  = state_chg | (|TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_gen_equations_sequencer.sv
// Self-checking bench: random netlists of nodes/elements are walked against a
// transaction-level expectation of step order and statistics, plus directed fault cases.
module tb_gen_equations_sequencer;

  localparam int unsigned NC      = 4;
  localparam int          CNT_MAX = 255;

  localparam logic [11:0] G_NONE    = 12'h000;
  localparam logic [11:0] G_RESET   = 12'h800;
  localparam logic [11:0] G_INIT    = 12'h400;
  localparam logic [11:0] G_CHOOSE  = 12'h200;
  localparam logic [11:0] G_STATUS  = 12'h100;
  localparam logic [11:0] G_TYPE    = 12'h080;
  localparam logic [11:0] G_VOLT    = 12'h040;
  localparam logic [11:0] G_CURR    = 12'h020;
  localparam logic [11:0] G_SELF    = 12'h010;
  localparam logic [11:0] G_OTHER   = 12'h008;
  localparam logic [11:0] G_COMPUTE = 12'h004;
  localparam logic [11:0] G_RES     = 12'h002;
  localparam logic [11:0] G_NEXT    = 12'h001;

  logic       clk = 1'b0;
  logic       program_reset_n, start_process, abort;
  logic       data_reset_done, matrix_initialized, node_chosen, loop_done;
  logic       status_checked, node_valid, type_checked, stamp_done;
  logic [2:0] elem_type;
  logic       self_data_got, other_data_got, compute_done, next_element_got, end_of_list;
  logic       go_reset_data, go_initialize_matrix, go_choose_node, go_check_node_status;
  logic       go_check_element_type, go_voltage, go_current, go_get_self_data;
  logic       go_get_other_data, go_compute, go_resistor, go_get_next_element;
  logic [3:0] compute_idx;
  logic       end_process, error, busy;
  logic [1:0] error_code;
  logic [7:0] elem_count, node_count;
  logic [3:0] state;
  logic [11:0] gov;

  int total = 0;
  int bad   = 0;
  int maxdly = 2;
  int exp_nodes = 0;
  int exp_elems = 0;

  always #5 clk = ~clk;

  assign gov = {go_reset_data, go_initialize_matrix, go_choose_node, go_check_node_status,
                go_check_element_type, go_voltage, go_current, go_get_self_data,
                go_get_other_data, go_compute, go_resistor, go_get_next_element};

  gen_equations_sequencer #(
    .NUM_COMPUTE(NC),
    .CW(4),
    .CNT_W(8),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .program_reset_n(program_reset_n), .start_process(start_process), .abort(abort),
    .data_reset_done(data_reset_done), .matrix_initialized(matrix_initialized),
    .node_chosen(node_chosen), .loop_done(loop_done), .status_checked(status_checked),
    .node_valid(node_valid), .type_checked(type_checked), .elem_type(elem_type),
    .stamp_done(stamp_done), .self_data_got(self_data_got), .other_data_got(other_data_got),
    .compute_done(compute_done), .next_element_got(next_element_got), .end_of_list(end_of_list),
    .go_reset_data(go_reset_data), .go_initialize_matrix(go_initialize_matrix),
    .go_choose_node(go_choose_node), .go_check_node_status(go_check_node_status),
    .go_check_element_type(go_check_element_type), .go_voltage(go_voltage),
    .go_current(go_current), .go_get_self_data(go_get_self_data),
    .go_get_other_data(go_get_other_data), .go_compute(go_compute),
    .go_resistor(go_resistor), .go_get_next_element(go_get_next_element),
    .compute_idx(compute_idx), .end_process(end_process), .error(error),
    .error_code(error_code), .busy(busy), .elem_count(elem_count),
    .node_count(node_count), .state(state)
  );

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    data_reset_done = 0; matrix_initialized = 0; node_chosen = 0; loop_done = 0;
    status_checked = 0; node_valid = 0; type_checked = 0; elem_type = 3'b000;
    stamp_done = 0; self_data_got = 0; other_data_got = 0; compute_done = 0;
    next_element_got = 0; end_of_list = 0;
  endtask

  // Random wait with all handshakes low; the step must still be requested.
  task automatic idle_expect(input logic [11:0] g, input string tag);
    int d;
    d = $urandom_range(0, maxdly);
    repeat (d) cyc();
    chk(tag, 32'(gov), 32'(g));
  endtask

  task automatic start_run();
    chk("idle_go", 32'(gov), 32'(G_RESET));
    start_process = 1; data_reset_done = 1; cyc(); clr();
    exp_nodes = 0; exp_elems = 0;
    chk("clr_elem", 32'(elem_count), 0);
    chk("clr_node", 32'(node_count), 0);
    chk("clr_code", 32'(error_code), 0);
    idle_expect(G_INIT, "init_go");
    matrix_initialized = 1; cyc(); clr();
  endtask

  task automatic choose_node(input bit valid);
    idle_expect(G_CHOOSE, "choose_go");
    node_chosen = 1; loop_done = 1'($urandom_range(0, 1)); cyc(); clr();
    idle_expect(G_STATUS, "status_go");
    status_checked = 1; node_valid = valid; cyc(); clr();
    if (valid) exp_nodes = sat_inc(exp_nodes);
    chk("node_cnt", 32'(node_count), 32'(exp_nodes));
  endtask

  task automatic dispatch(input int ty);
    idle_expect(G_TYPE, "type_go");
    type_checked = 1;
    elem_type = (ty == 0) ? 3'b001 : (ty == 1) ? 3'b010 : 3'b100;
    cyc(); clr();
  endtask

  task automatic do_element(input int ty, input bit last);
    dispatch(ty);
    if (ty == 2) begin
      idle_expect(G_SELF, "self_go");
      chk("self_idx", 32'(compute_idx), 0);
      self_data_got = 1; cyc(); clr();
      idle_expect(G_OTHER, "other_go");
      other_data_got = 1; cyc(); clr();
      for (int p = 0; p < int'(NC); p++) begin
        idle_expect(G_COMPUTE, "compute_go");
        chk("compute_idx", 32'(compute_idx), 32'(p));
        compute_done = 1; cyc(); clr();
      end
      idle_expect(G_RES, "res_go");
      chk("res_idx", 32'(compute_idx), 0);
    end else begin
      idle_expect((ty == 0) ? G_VOLT : G_CURR, "stamp_go");
    end
    stamp_done = 1; cyc(); clr();
    exp_elems = sat_inc(exp_elems);
    chk("elem_cnt", 32'(elem_count), 32'(exp_elems));
    idle_expect(G_NEXT, "next_go");
    if (last) begin
      end_of_list = 1; next_element_got = 1'($urandom_range(0, 1));
    end else begin
      next_element_got = 1;
    end
    cyc(); clr();
  endtask

  task automatic finish_run();
    idle_expect(G_CHOOSE, "final_choose");
    loop_done = 1; cyc(); clr();
    chk("done_go", 32'(gov), 32'(G_NONE));
    chk("done_end", 32'(end_process), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_nodes", 32'(node_count), 32'(exp_nodes));
    chk("done_elems", 32'(elem_count), 32'(exp_elems));
    repeat (3) cyc();
    chk("done_hold", 32'(end_process), 1);
    start_process = 0; cyc();
    chk("rearm_go", 32'(gov), 32'(G_RESET));
    chk("rearm_end", 32'(end_process), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0] bad_types [5];
    int nn, ne;
    bad_types = '{3'b011, 3'b000, 3'b101, 3'b110, 3'b111};

    program_reset_n = 0; start_process = 0; abort = 0; clr();
    repeat (2) @(negedge clk);
    chk("rst_go", 32'(gov), 32'(G_RESET));
    chk("rst_idx", 32'(compute_idx), 0);
    chk("rst_elem", 32'(elem_count), 0);
    chk("rst_node", 32'(node_count), 0);
    chk("rst_code", 32'(error_code), 0);
    chk("rst_flags", 32'({end_process, error, busy}), 0);
    program_reset_n = 1; cyc();
    chk("idle_wait_go", 32'(gov), 32'(G_RESET));

    // Random netlists: nodes valid or not, each valid node with 1..3 mixed elements.
    for (int s = 0; s < 6; s++) begin
      start_run();
      nn = $urandom_range(1, 4);
      for (int n = 0; n < nn; n++) begin
        if ($urandom_range(0, 3) != 0) begin
          choose_node(1);
          ne = $urandom_range(1, 3);
          for (int e = 0; e < ne; e++) do_element($urandom_range(0, 2), e == ne - 1);
        end else begin
          choose_node(0);
        end
      end
      finish_run();
    end

    // Bad element types: spec case 011 first, then a random other illegal code.
    for (int b = 0; b < 2; b++) begin
      start_run();
      choose_node(1);
      idle_expect(G_TYPE, "bt_type_go");
      type_checked = 1;
      elem_type = (b == 0) ? bad_types[0] : bad_types[$urandom_range(1, 4)];
      cyc(); clr();
      chk("bt_error", 32'(error), 1);
      chk("bt_code", 32'(error_code), 1);
      chk("bt_go", 32'(gov), 32'(G_NONE));
      chk("bt_busy", 32'(busy), 0);
      repeat (2) cyc();
      chk("bt_hold", 32'(error), 1);
      start_process = 0; cyc();
      chk("bt_idle_go", 32'(gov), 32'(G_RESET));
      chk("bt_idle_err", 32'(error), 0);
      chk("bt_code_kept", 32'(error_code), 1);
    end

    // Abort during COMPUTE at phase 2, with compute_done also high.
    start_run();
    choose_node(1);
    dispatch(2);
    self_data_got = 1; cyc(); clr();
    other_data_got = 1; cyc(); clr();
    compute_done = 1; cyc(); cyc(); clr();
    chk("ab_idx", 32'(compute_idx), 2);
    chk("ab_pre_go", 32'(gov), 32'(G_COMPUTE));
    abort = 1; compute_done = 1; cyc(); clr(); abort = 0;
    chk("ab_go", 32'(gov), 32'(G_RESET));
    chk("ab_busy", 32'(busy), 0);
    chk("ab_node", 32'(node_count), 1);
    chk("ab_elem", 32'(elem_count), 0);
    start_process = 0; cyc();

    // Stall in OTHER for 8 cycles.
    start_run();
    choose_node(1);
    dispatch(2);
    self_data_got = 1; cyc(); clr();
    repeat (7) cyc();
    chk("wd_pre_go", 32'(gov), 32'(G_OTHER));
    cyc();
`ifdef GEN_EQ_WATCHDOG_EN
    chk("wd_error", 32'(error), 1);
    chk("wd_code", 32'(error_code), 2);
`else
    chk("wd_stay_go", 32'(gov), 32'(G_OTHER));
    chk("wd_no_err", 32'(error), 0);
`endif
    abort = 1; cyc(); abort = 0;
    chk("wd_abort_go", 32'(gov), 32'(G_RESET));
    start_process = 0; cyc();

    // Asynchronous reset while in VOLT, between clock edges.
    start_run();
    choose_node(1);
    dispatch(0);
    chk("ar_volt_go", 32'(gov), 32'(G_VOLT));
    #2 program_reset_n = 0;
    #1;
    chk("ar_go", 32'(gov), 32'(G_RESET));
    chk("ar_node", 32'(node_count), 0);
    chk("ar_busy", 32'(busy), 0);
    @(negedge clk);
    program_reset_n = 1; start_process = 0; cyc();
    chk("ar_after_go", 32'(gov), 32'(G_RESET));

    // 300 voltage elements on one node: elem_count saturates.
    maxdly = 0;
    start_run();
    choose_node(1);
    for (int e = 0; e < 300; e++) do_element(0, e == 299);
    chk("sat_elem", 32'(elem_count), 255);
    finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
